// File: rtl/axis_bram_xfer_sequencer.sv
// rtl/axis_bram_xfer_sequencer.sv - command-driven AXI-lite programmer and stream completion watcher for the BRAM adapter
//
// Ports:
//   aclk/areset            clock, asynchronous active-high reset
//   cmd_*                  transfer command (rw, start, end) with valid/ready handshake
//   m_axi_aw*/w*/b*        AXI-lite write master towards the adapter register slave
//   mon_s_* / mon_m_*      passive taps of the adapter s00 (stream->BRAM) and m00 (BRAM->stream)
//   busy/done/err          transfer status; err_code and beat_count held until the next accept
module axis_bram_xfer_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int REG_AW    = 5,
    parameter int CTRL_OFS  = 0,
    parameter int START_OFS = 4,
    parameter int END_OFS   = 8,
    parameter int TIMEOUT   = 65535
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_start_addr,
    input  logic [ADDR_W-1:0] cmd_end_addr,
    output logic [REG_AW-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    input  logic              mon_s_tvalid,
    input  logic              mon_s_tready,
    input  logic              mon_s_tlast,
    input  logic              mon_m_tvalid,
    input  logic              mon_m_tready,
    input  logic              mon_m_tlast,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       beat_count
);

    // Write states are kept contiguous so is_wr() is a simple range test.
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_W_START  = 4'd1;
    localparam logic [3:0] S_W_END    = 4'd2;
    localparam logic [3:0] S_W_ARM    = 4'd3;
    localparam logic [3:0] S_W_RELOAD = 4'd4;
    localparam logic [3:0] S_W_RUN    = 4'd5;
    localparam logic [3:0] S_RUN      = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_ERR      = 4'd8;

    localparam logic [1:0]  E_NONE  = 2'd0;
    localparam logic [1:0]  E_RANGE = 2'd1;
    localparam logic [1:0]  E_BRESP = 2'd2;
    localparam logic [1:0]  E_TOUT  = 2'd3;
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

    logic [3:0]        state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] start_q, start_d, end_q, end_d;
    logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [15:0]       beat_count_q, beat_count_d, idle_q, idle_d;
    logic [REG_AW-1:0] addr_c;
    logic [31:0]       data_c;
    logic              b_hs, beat, last;

    function automatic logic is_wr(input logic [3:0] s);
        return (s >= S_W_START) && (s <= S_W_RUN);
    endfunction

    // Register address and payload are a pure function of the state and the latched command,
    // so they cannot move while a valid is pending.
    always_comb begin
        addr_c = '0;
        data_c = '0;
        case (state_q)
            S_W_START:  begin addr_c = REG_AW'(START_OFS); data_c = 32'(start_q); end
            S_W_END:    begin addr_c = REG_AW'(END_OFS);   data_c = 32'(end_q);   end
            S_W_ARM:    begin addr_c = REG_AW'(CTRL_OFS);  data_c = {30'b0, 1'b0, rw_q}; end
            S_W_RELOAD: begin addr_c = REG_AW'(CTRL_OFS);  data_c = {30'b0, 1'b1, rw_q}; end
            S_W_RUN:    begin addr_c = REG_AW'(CTRL_OFS);  data_c = {30'b0, 1'b0, rw_q}; end
            default:    begin addr_c = '0; data_c = '0; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        start_d      = start_q;
        end_d        = end_q;
        err_code_d   = err_code_q;
        beat_count_d = beat_count_q;
        idle_d       = idle_q;
        awvalid_d    = awvalid_q && !m_axi_awready;
        wvalid_d     = wvalid_q && !m_axi_wready;
        bready_d     = bready_q && !m_axi_bvalid;
        b_hs         = bready_q && m_axi_bvalid;
        // Only the stream selected by the latched direction is watched.
        beat         = rw_q ? (mon_s_tvalid && mon_s_tready) : (mon_m_tvalid && mon_m_tready);
        last         = rw_q ? mon_s_tlast : mon_m_tlast;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rw_d         = cmd_rw;
                    start_d      = cmd_start_addr;
                    end_d        = cmd_end_addr;
                    beat_count_d = '0;
                    idle_d       = '0;
                    if (cmd_start_addr > cmd_end_addr) begin
                        err_code_d = E_RANGE;
                        state_d    = S_ERR;
                    end else begin
                        err_code_d = E_NONE;
                        state_d    = S_W_START;
                    end
                end
            end
            S_W_START, S_W_END, S_W_ARM, S_W_RELOAD, S_W_RUN: begin
                if (b_hs) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_code_d = E_BRESP;
                        state_d    = S_ERR;
                    end else begin
                        state_d = state_q + 4'd1;
                    end
                end
            end
            S_RUN: begin
                if (beat) begin
                    idle_d = '0;
                    if (beat_count_q != 16'hFFFF) beat_count_d = beat_count_q + 16'd1;
                    if (last) state_d = S_DONE;
                end else if (TIMEOUT != 0 && idle_q == IDLE_LAST) begin
                    err_code_d = E_TOUT;
                    state_d    = S_ERR;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every write state opens with a fresh AW+W pair and an open B channel.
        if (is_wr(state_d) && state_d != state_q) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
        end else if (!is_wr(state_d)) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= S_IDLE;
            rw_q         <= 1'b0;
            start_q      <= '0;
            end_q        <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            err_code_q   <= E_NONE;
            beat_count_q <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            start_q      <= start_d;
            end_q        <= end_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            err_code_q   <= err_code_d;
            beat_count_q <= beat_count_d;
            idle_q       <= idle_d;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign err           = (state_q == S_ERR);
    assign err_code      = err_code_q;
    assign beat_count    = beat_count_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_awaddr  = awvalid_q ? addr_c : '0;
    assign m_axi_wdata   = wvalid_q ? data_c : '0;
    assign m_axi_wstrb   = 4'b1111;

endmodule
